// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired register-to-register control unit:
// sequencer states, opcode encodings, alu_sel bit positions and instruction classes.
package cu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU3,
    CL_UNARY,
    CL_MULDIV,
    CL_NOP,
    CL_HALT,
    CL_ILLEGAL
  } iclass_e;

  localparam int unsigned ALU_W = 13;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int unsigned SEL_ADD  = 0;
  localparam int unsigned SEL_SUB  = 1;
  localparam int unsigned SEL_MUL  = 2;
  localparam int unsigned SEL_DIV  = 3;
  localparam int unsigned SEL_AND  = 4;
  localparam int unsigned SEL_OR   = 5;
  localparam int unsigned SEL_SHR  = 6;
  localparam int unsigned SEL_SHRA = 7;
  localparam int unsigned SEL_SHL  = 8;
  localparam int unsigned SEL_ROR  = 9;
  localparam int unsigned SEL_ROL  = 10;
  localparam int unsigned SEL_NEG  = 11;
  localparam int unsigned SEL_NOT  = 12;

  function automatic logic [ALU_W-1:0] sel_onehot(input int unsigned idx);
    return ALU_W'(1) << idx;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decode: instruction class plus the one-hot ALU
// operation it requests (zero for non-ALU classes).
module cu_decode
  import cu_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0]   op_i,
  output iclass_e          cls_o,
  output logic [ALU_W-1:0] alu_sel_o
);

  always_comb begin
    cls_o     = CL_ILLEGAL;
    alu_sel_o = '0;
    case (op_i)
      OPW'(OP_ADD):  begin cls_o = CL_ALU3;   alu_sel_o = sel_onehot(SEL_ADD);  end
      OPW'(OP_SUB):  begin cls_o = CL_ALU3;   alu_sel_o = sel_onehot(SEL_SUB);  end
      OPW'(OP_AND):  begin cls_o = CL_ALU3;   alu_sel_o = sel_onehot(SEL_AND);  end
      OPW'(OP_OR):   begin cls_o = CL_ALU3;   alu_sel_o = sel_onehot(SEL_OR);   end
      OPW'(OP_ROR):  begin cls_o = CL_ALU3;   alu_sel_o = sel_onehot(SEL_ROR);  end
      OPW'(OP_ROL):  begin cls_o = CL_ALU3;   alu_sel_o = sel_onehot(SEL_ROL);  end
      OPW'(OP_SHR):  begin cls_o = CL_ALU3;   alu_sel_o = sel_onehot(SEL_SHR);  end
      OPW'(OP_SHRA): begin cls_o = CL_ALU3;   alu_sel_o = sel_onehot(SEL_SHRA); end
      OPW'(OP_SHL):  begin cls_o = CL_ALU3;   alu_sel_o = sel_onehot(SEL_SHL);  end
      OPW'(OP_DIV):  begin cls_o = CL_MULDIV; alu_sel_o = sel_onehot(SEL_DIV);  end
      OPW'(OP_MUL):  begin cls_o = CL_MULDIV; alu_sel_o = sel_onehot(SEL_MUL);  end
      OPW'(OP_NEG):  begin cls_o = CL_UNARY;  alu_sel_o = sel_onehot(SEL_NEG);  end
      OPW'(OP_NOT):  begin cls_o = CL_UNARY;  alu_sel_o = sel_onehot(SEL_NOT);  end
      OPW'(OP_NOP):  cls_o = CL_NOP;
      OPW'(OP_HALT): cls_o = CL_HALT;
      default:       ;
    endcase
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, class-dependent execute T3-T6,
// Moore strobes decoded from the state register and the IR opcode.
module alu_control_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDMuxread,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [12:0] alu_sel,
  output logic        run,
  output logic        illegal_op
);

  state_e             state_q, state_d;
  logic               illegal_q, illegal_d;
  iclass_e            cls;
  logic [ALU_W-1:0]   op_sel;

  // Register fields are consumed by the datapath's select-and-encode logic.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[31-OPW:0];

  cu_decode #(.OPW(OPW)) u_decode (
    .op_i      (IR[31 -: OPW]),
    .cls_o     (cls),
    .alu_sel_o (op_sel)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (cls)
          CL_ALU3, CL_UNARY, CL_MULDIV: state_d = ST_T4;
          CL_HALT:                      state_d = ST_HALT;
          CL_ILLEGAL: begin
            state_d   = ST_T0;
            illegal_d = 1'b1;
          end
          default:                      state_d = ST_T0;
        endcase
      end
      ST_T4:   state_d = (cls == CL_ALU3 || cls == CL_MULDIV) ? ST_T5 : ST_T0;
      ST_T5:   state_d = (cls == CL_MULDIV) ? ST_T6 : ST_T0;
      ST_T6:   state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin} = '0;
    {Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin}       = '0;
    {Gra, Grb, Grc, Rin, Rout}                                  = '0;
    alu_sel    = '0;
    run        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    // Flag is visible already in the offending T3, then held by the flop.
    illegal_op = illegal_q || (state_q == ST_T3 && cls == CL_ILLEGAL);
    case (state_q)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
      ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; MDMuxread = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (cls)
          CL_ALU3:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_UNARY:  begin Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; alu_sel = op_sel; end
          CL_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          default:   ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CL_ALU3:   begin Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; alu_sel = op_sel; end
          CL_UNARY:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_MULDIV: begin
            Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1; alu_sel = op_sel;
          end
          default:   ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CL_ALU3:   begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
          default:   ;
        endcase
      end
      ST_T6: begin
        if (cls == CL_MULDIV) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: per-cycle comparison against an
// instruction-level plan of expected strobes, table vectors, corner sequences, random mix.
module tb_alu_control_sequencer;

  logic        clock, clear;
  logic [31:0] IR;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin;
  logic Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout;
  logic [12:0] alu_sel;
  logic run, illegal_op;

  alu_control_sequencer #(.OPW(5)) dut (
    .clock(clock), .clear(clear), .IR(IR),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .MDMuxread(MDMuxread), .IRin(IRin),
    .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .alu_sel(alu_sel), .run(run), .illegal_op(illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [19:0] M_PCOUT    = 20'b1 << 0;
  localparam logic [19:0] M_PCIN     = 20'b1 << 1;
  localparam logic [19:0] M_INCPC    = 20'b1 << 2;
  localparam logic [19:0] M_MARIN    = 20'b1 << 3;
  localparam logic [19:0] M_MDRIN    = 20'b1 << 4;
  localparam logic [19:0] M_MDROUT   = 20'b1 << 5;
  localparam logic [19:0] M_MDMUX    = 20'b1 << 6;
  localparam logic [19:0] M_IRIN     = 20'b1 << 7;
  localparam logic [19:0] M_YIN      = 20'b1 << 8;
  localparam logic [19:0] M_ZLOWIN   = 20'b1 << 9;
  localparam logic [19:0] M_ZHIGHIN  = 20'b1 << 10;
  localparam logic [19:0] M_ZLOWOUT  = 20'b1 << 11;
  localparam logic [19:0] M_ZHIGHOUT = 20'b1 << 12;
  localparam logic [19:0] M_HIIN     = 20'b1 << 13;
  localparam logic [19:0] M_LOIN     = 20'b1 << 14;
  localparam logic [19:0] M_GRA      = 20'b1 << 15;
  localparam logic [19:0] M_GRB      = 20'b1 << 16;
  localparam logic [19:0] M_GRC      = 20'b1 << 17;
  localparam logic [19:0] M_RIN      = 20'b1 << 18;
  localparam logic [19:0] M_ROUT     = 20'b1 << 19;

  typedef struct {
    logic [19:0] strb;
    logic [12:0] alu;
    logic        run;
    logic        ill;
  } cyc_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          cpi;
  } vec_t;

  cyc_t plan_q[$];
  int   vectors, miscompares;
  logic m_ill;

  function automatic logic [34:0] sample();
    return {run, illegal_op, alu_sel,
            Rout, Rin, Grc, Grb, Gra, LOin, HIin, Zhighout, Zlowout, Zhighin,
            Zlowin, Yin, IRin, MDMuxread, MDRout, MDRin, MARin, IncPC, PCin, PCout};
  endfunction

  function automatic cyc_t mk(logic [19:0] s, int alu_bit, logic r, logic il);
    cyc_t c;
    c.strb = s;
    c.alu  = (alu_bit < 0) ? 13'h0 : (13'h1 << alu_bit);
    c.run  = r;
    c.ill  = il;
    return c;
  endfunction

  // ALU bit for each opcode as listed in the operation table; -1 if none.
  function automatic int alu_bit_of(logic [4:0] op);
    case (op)
      5'd3:  return 0;   // ADD
      5'd4:  return 1;   // SUB
      5'd5:  return 4;   // AND
      5'd6:  return 5;   // OR
      5'd7:  return 9;   // ROR
      5'd8:  return 10;  // ROL
      5'd9:  return 6;   // SHR
      5'd10: return 7;   // SHRA
      5'd11: return 8;   // SHL
      5'd15: return 3;   // DIV
      5'd16: return 2;   // MUL
      5'd17: return 11;  // NEG
      5'd18: return 12;  // NOT
      default: return -1;
    endcase
  endfunction

  task automatic plan(input logic [31:0] ir);
    logic [4:0] op;
    int         b;
    op = ir[31:27];
    b  = alu_bit_of(op);
    plan_q.delete();
    plan_q.push_back(mk(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, -1, 1'b1, 1'b0));
    plan_q.push_back(mk(M_ZLOWOUT | M_PCIN | M_MDMUX | M_MDRIN, -1, 1'b1, 1'b0));
    plan_q.push_back(mk(M_MDROUT | M_IRIN, -1, 1'b1, 1'b0));
    if (op >= 5'd3 && op <= 5'd11) begin
      plan_q.push_back(mk(M_GRB | M_ROUT | M_YIN, -1, 1'b1, 1'b0));
      plan_q.push_back(mk(M_GRC | M_ROUT | M_ZLOWIN, b, 1'b1, 1'b0));
      plan_q.push_back(mk(M_ZLOWOUT | M_GRA | M_RIN, -1, 1'b1, 1'b0));
    end else if (op == 5'd17 || op == 5'd18) begin
      plan_q.push_back(mk(M_GRB | M_ROUT | M_ZLOWIN, b, 1'b1, 1'b0));
      plan_q.push_back(mk(M_ZLOWOUT | M_GRA | M_RIN, -1, 1'b1, 1'b0));
    end else if (op == 5'd15 || op == 5'd16) begin
      plan_q.push_back(mk(M_GRA | M_ROUT | M_YIN, -1, 1'b1, 1'b0));
      plan_q.push_back(mk(M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN, b, 1'b1, 1'b0));
      plan_q.push_back(mk(M_ZLOWOUT | M_LOIN, -1, 1'b1, 1'b0));
      plan_q.push_back(mk(M_ZHIGHOUT | M_HIIN, -1, 1'b1, 1'b0));
    end else if (op == 5'd26 || op == 5'd27) begin
      plan_q.push_back(mk(20'h0, -1, 1'b1, 1'b0));
    end else begin
      plan_q.push_back(mk(20'h0, -1, 1'b1, 1'b1));
    end
  endtask

  task automatic check(input string name, input cyc_t e);
    logic [34:0] act, exp;
    act = sample();
    exp = {e.run, m_ill | e.ill, e.alu, e.strb};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got run/ill/alu/strb=%b/%b/%h/%h want %b/%b/%h/%h",
               name, $time, act[34], act[33], act[32:20], act[19:0],
               exp[34], exp[33], exp[32:20], exp[19:0]);
    end
    m_ill = m_ill | e.ill;
  endtask

  // Start in T0 (at negedge+1); lim=0 runs the full instruction, otherwise stop in cycle lim-1.
  task automatic run_instr(input string name, input logic [31:0] ir, input int lim,
                           output int cpi);
    IR  = ir;
    cpi = 0;
    plan(ir);
    for (int k = 0; k < plan_q.size(); k++) begin
      check($sformatf("%s_c%0d", name, k), plan_q[k]);
      if (lim != 0 && k + 1 == lim) break;
      @(negedge clock); #1;
      if (PCout === 1'b1 && cpi == 0) cpi = k + 1;
    end
  endtask

  task automatic reset_seq();
    cyc_t z;
    z = mk(20'h0, -1, 1'b0, 1'b0);
    clear = 1'b0;
    m_ill = 1'b0;
    #1 check("reset", z);
    @(negedge clock); #1;
    check("reset_hold", z);
    clear = 1'b1;
    #1 check("idle_after_release", z);
    @(negedge clock); #1;
  endtask

  vec_t tbl[9];

  initial begin
    int   cpi;
    cyc_t z;
    vectors     = 0;
    miscompares = 0;
    m_ill       = 1'b0;
    clear       = 1'b0;
    IR          = 32'h0;

    tbl[0] = '{"NEG",  32'h8B380000, 5};
    tbl[1] = '{"ADD",  32'h19890000, 6};
    tbl[2] = '{"MUL",  32'h81A00000, 7};
    tbl[3] = '{"NOP",  32'hD0000000, 4};
    tbl[4] = '{"DIV",  32'h78900000, 7};
    tbl[5] = '{"NOT",  32'h91180000, 5};
    tbl[6] = '{"SHRA", 32'h51100000, 6};
    tbl[7] = '{"ROL",  32'h40880000, 6};
    tbl[8] = '{"ILL",  32'h00000000, 4};

    @(negedge clock);
    reset_seq();

    for (int i = 0; i < 9; i++) begin
      run_instr(tbl[i].name, tbl[i].ir, 0, cpi);
      vectors++;
      if (cpi != tbl[i].cpi) begin
        miscompares++;
        $display("FAIL cpi_%s: got %0d want %0d", tbl[i].name, cpi, tbl[i].cpi);
      end
    end

    // Clear pulsed in T4 of an ADD: immediate IDLE, sticky flag dropped.
    z = mk(20'h0, -1, 1'b0, 1'b0);
    run_instr("ADD_abort", 32'h19890000, 5, cpi);
    clear = 1'b0;
    m_ill = 1'b0;
    #1 check("clear_mid_T4", z);
    @(negedge clock); #1;
    check("clear_mid_hold", z);
    clear = 1'b1;
    #1 check("clear_mid_release", z);
    @(negedge clock); #1;
    run_instr("ADD_after_clear", 32'h19890000, 0, cpi);

    // HALT parks with run low for 20 cycles.
    run_instr("HALT", 32'hD8000000, 0, cpi);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halt_hold_%0d", i), z);
      @(negedge clock); #1;
    end

    reset_seq();
    for (int n = 0; n < 200; n++) begin
      logic [4:0] op;
      logic [4:0] legal [14];
      legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                5'd15, 5'd16, 5'd17, 5'd18, 5'd26};
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      else                           op = legal[$urandom_range(0, 13)];
      if (op == 5'd27) op = 5'd26;
      run_instr($sformatf("rnd%0d", n), {op, 27'($urandom)}, 0, cpi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
